mmio_memory: RTL
================

MMIO_MEMORY -- requirements
Module: mmio_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 15, address width.
REQ-003 SHALL have parameter RAM_WORDS, default 16384, general RAM depth, based at address 0.
REQ-004 SHALL have parameter SCREEN_WORDS, default 8192, screen buffer depth, based at RAM_WORDS.
REQ-005 SHALL have parameter KBD_DEPTH, default 4, keyboard FIFO depth; power of two, minimum 2.
REQ-006 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port in, input, DATA_W, write data.
REQ-009 SHALL have port write, input, 1, write strobe.
REQ-010 SHALL have port read, input, 1, read strobe; used only for keyboard pop and access checking.
REQ-011 SHALL have port address, input, ADDR_W, word address.
REQ-012 SHALL have port out, output, DATA_W, read data.
REQ-013 SHALL have port kbd_strobe, input, 1, one-cycle keycode push.
REQ-014 SHALL have port kbd_data, input, DATA_W, keycode.
REQ-015 SHALL have port bad_access, output, 1, registered one-cycle error pulse.

Function
REQ-016 Map SHALL be: RAM [0, RAM_WORDS); screen [RAM_WORDS, RAM_WORDS+SCREEN_WORDS); KBD_DATA = RAM_WORDS+SCREEN_WORDS; KBD_STAT = KBD_DATA+1; anything else unmapped.
REQ-017 RAM/screen write SHALL take effect at the clock edge when write=1; out SHALL be combinational from address and current storage (0-cycle read latency).
REQ-018 KBD_DATA read SHALL return the FIFO head, or 0 when the FIFO is empty.
REQ-019 KBD_STAT read SHALL return bit0 not_empty, bit1 full, bit2 overflow (sticky), bits [3+:clog2(KBD_DEPTH)+1] count; remaining bits 0.
REQ-020 Pop SHALL occur at the edge when read=1 and address=KBD_DATA and the FIFO is not empty; pop on empty SHALL be ignored.
REQ-021 Push SHALL occur at the edge when kbd_strobe=1 and either not full or a pop occurs the same cycle.
REQ-022 Push and pop in the same cycle SHALL both occur with count unchanged; on an empty FIFO only the push occurs.
REQ-023 kbd_strobe while full with no same-cycle pop SHALL drop the keycode and set overflow.
REQ-024 A write to KBD_STAT with in[2]=1 SHALL clear overflow; when a set and a clear coincide, the set SHALL win.
REQ-025 Writes to KBD_DATA SHALL be ignored and SHALL NOT flag bad_access.
REQ-026 Unmapped reads SHALL return 0; unmapped writes SHALL change no state.
REQ-027 bad_access SHALL be high for exactly the cycle after a read or write to an unmapped address.
REQ-028 FIFO pointers SHALL wrap modulo KBD_DEPTH; count SHALL range 0..KBD_DEPTH.

Reset
REQ-029 While reset_n=0: FIFO empty (pointers and count 0), overflow 0, bad_access 0.
REQ-030 RAM, screen and FIFO storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-cycle SHALL discard any push, pop or write at that edge.

Structure
REQ-032 Shared package mem_map_pkg SHALL hold the base-address calculation functions and the KBD_STAT bit positions.
REQ-033 The keyboard FIFO SHALL be a sub-module kbd_fifo (push, pop, head, count, full, empty, overflow).

Verification
REQ-034 Write 0x1234 @0x0005, then read @0x0005 -> out=0x1234 in the same cycle; screen @0x4005 is unchanged.
REQ-035 Push 0x0041, 0x0042; read KBD_STAT -> 0x0011; pop twice -> 0x0041 then 0x0042; then KBD_DATA -> 0.
REQ-036 Push 5 codes with KBD_DEPTH=4 -> count 4, overflow=1, 5th code lost; write KBD_STAT in=0x0004 -> overflow=0.
REQ-037 Full FIFO with push and pop in the same cycle -> count stays 4, overflow stays 0, head advances.
REQ-038 Read @0x6002 with default parameters -> out=0 and bad_access pulses one cycle; reset_n low with 3 queued codes -> STAT reads 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map helpers and keyboard status bit positions
package mem_map_pkg;

  // Bit positions inside the KBD_STAT word
  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERFLOW_BIT  = 2;
  localparam int STAT_COUNT_LSB     = 3;

  // Screen buffer sits directly above general RAM
  function automatic int screen_base(input int ram_words);
    return ram_words;
  endfunction

  // Keyboard data register sits directly above the screen buffer
  function automatic int kbd_data_addr(input int ram_words, input int screen_words);
    return screen_base(ram_words) + screen_words;
  endfunction

  // Keyboard status register follows the data register
  function automatic int kbd_stat_addr(input int ram_words, input int screen_words);
    return kbd_data_addr(ram_words, screen_words) + 1;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - keyboard keycode FIFO with sticky overflow flag
module kbd_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic                         i_pop,
  input  logic                         i_clr_ovf,
  output logic [DATA_W-1:0]            o_head,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  // Pointers, occupancy and sticky overflow; set beats a coincident clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  // Keycode storage is not reset; a push is discarded while reset is held
  always_ff @(posedge i_clock) begin
    if (i_reset_n && w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mmio_memory.sv
// rtl/mmio_memory.sv - RAM, screen buffer and keyboard registers on one word bus
module mmio_memory
  import mem_map_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  input  logic              kbd_strobe,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              bad_access
);

  localparam int          MEM_WORDS  = screen_base(RAM_WORDS) + SCREEN_WORDS;
  localparam int          MEM_AW     = $clog2(MEM_WORDS);
  localparam int          CNT_W      = $clog2(KBD_DEPTH) + 1;
  localparam logic [31:0] MEM_END    = 32'(MEM_WORDS);
  localparam logic [31:0] KBD_DATA_A = 32'(kbd_data_addr(RAM_WORDS, SCREEN_WORDS));
  localparam logic [31:0] KBD_STAT_A = 32'(kbd_stat_addr(RAM_WORDS, SCREEN_WORDS));

  // RAM and screen share one array since they are contiguous from address 0
  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic              r_bad_access;

  logic [31:0]       w_addr32;
  logic [MEM_AW-1:0] w_mem_idx;
  logic              w_is_mem;
  logic              w_is_kd;
  logic              w_is_ks;
  logic              w_unmapped;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_overflow;
  logic [DATA_W-1:0] w_stat;
  logic [DATA_W-1:0] w_out;

  assign w_addr32   = 32'(address);
  assign w_mem_idx  = w_addr32[MEM_AW-1:0];
  assign w_is_mem   = (w_addr32 < MEM_END);
  assign w_is_kd    = (w_addr32 == KBD_DATA_A);
  assign w_is_ks    = (w_addr32 == KBD_STAT_A);
  assign w_unmapped = ~(w_is_mem | w_is_kd | w_is_ks);

  kbd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (KBD_DEPTH)
  ) u_kbd_fifo (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_push      (kbd_strobe),
    .i_push_data (kbd_data),
    .i_pop       (read & w_is_kd),
    .i_clr_ovf   (write & w_is_ks & in[STAT_OVERFLOW_BIT]),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overflow  (w_overflow)
  );

  // Word storage; writes held off while reset is asserted
  always_ff @(posedge clock) begin
    if (reset_n && write && w_is_mem) r_mem[w_mem_idx] <= in;
  end

  // One-cycle error pulse following any access to an unmapped address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_bad_access <= 1'b0;
    else          r_bad_access <= (read | write) & w_unmapped;
  end

  // Assemble the keyboard status word
  always_comb begin
    w_stat = '0;
    w_stat[STAT_NOT_EMPTY_BIT]       = ~w_empty;
    w_stat[STAT_FULL_BIT]            = w_full;
    w_stat[STAT_OVERFLOW_BIT]        = w_overflow;
    w_stat[STAT_COUNT_LSB +: CNT_W]  = w_count;
  end

  // Zero-latency read mux; empty FIFO and unmapped space read as 0
  always_comb begin
    w_out = '0;
    if (w_is_mem)                 w_out = r_mem[w_mem_idx];
    else if (w_is_kd && !w_empty) w_out = w_head;
    else if (w_is_ks)             w_out = w_stat;
  end

  assign out        = w_out;
  assign bad_access = r_bad_access;

endmodule
